// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle logic/arith ops plus a shift-add multiplier.
// One request in flight; result is held until the consumer takes it.
module iter_alu #(
    parameter int WIDTH  = 64,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       OP,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] O,
    output logic             Ovf,
    output logic             Zero,
    output logic             Ill
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             ill_q, ill_d;

    logic [WIDTH-1:0] sum, diff, alu_o;
    logic             alu_ovf, alu_ill, sub_ovf, is_mul;
    logic [WIDTH:0]   step_sum;
    logic [2*WIDTH-1:0] acc_step;

    always_comb begin
        sum     = A + B;
        diff    = A - B;
        sub_ovf = (A[WIDTH-1] ^ B[WIDTH-1]) & (diff[WIDTH-1] ^ A[WIDTH-1]);
        is_mul  = MUL_EN && (OP == 4'b1000);
        alu_o   = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (OP)
            4'b0000: alu_o = A & B;
            4'b0001: alu_o = A | B;
            4'b0010: begin
                alu_o   = sum;
                alu_ovf = ~(A[WIDTH-1] ^ B[WIDTH-1]) & (sum[WIDTH-1] ^ A[WIDTH-1]);
            end
            4'b0110: begin
                alu_o   = diff;
                alu_ovf = sub_ovf;
            end
            // sign of the true difference survives a wrapped subtraction
            4'b0111: alu_o = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
            4'b1100: alu_o = ~(A | B);
            default: alu_ill = 1'b1;
        endcase
    end

    // Upper half accumulates, lower half shifts out multiplier bits LSB first
    always_comb begin
        step_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_step = {step_sum, acc_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        o_d     = o_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        ill_d   = ill_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (is_mul) begin
                        state_d = S_MUL;
                        cnt_d   = '0;
                        acc_d   = {{WIDTH{1'b0}}, B};
                        mcand_d = A;
                    end else begin
                        state_d = S_DONE;
                        o_d     = alu_o;
                        ovf_d   = alu_ovf;
                        zero_d  = (alu_o == '0);
                        ill_d   = alu_ill;
                    end
                end
            end
            S_MUL: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    o_d     = acc_step[WIDTH-1:0];
                    ovf_d   = |acc_step[2*WIDTH-1:WIDTH];
                    zero_d  = (acc_step[WIDTH-1:0] == '0);
                    ill_d   = 1'b0;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            o_q     <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            o_q     <= o_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            ill_q   <= ill_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign O         = o_q;
    assign Ovf       = ovf_q;
    assign Zero      = zero_q;
    assign Ill       = ill_q;

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu: a MUL-enabled and a MUL-disabled instance
// share operands; results are predicted from a wide-arithmetic model.
module tb_iter_alu;

    localparam int W = 64;

    typedef struct {
        logic [W-1:0] o;
        logic         ovf;
        logic         zero;
        logic         ill;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         iv0, iv1;
    logic [W-1:0] A, B;
    logic [3:0]   OP;
    logic         out_ready;
    logic         ir0, ov0, ovf0, z0, il0;
    logic         ir1, ov1, ovf1, z1, il1;
    logic [W-1:0] o0, o1;

    bit           sel;
    logic         s_ir, s_ov, s_ovf, s_z, s_il;
    logic [W-1:0] s_o;

    int checks   = 0;
    int failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    iter_alu #(.WIDTH(W), .MUL_EN(1'b1)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0),
        .A(A), .B(B), .OP(OP), .out_valid(ov0), .out_ready(out_ready),
        .O(o0), .Ovf(ovf0), .Zero(z0), .Ill(il0)
    );

    iter_alu #(.WIDTH(W), .MUL_EN(1'b0)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .A(A), .B(B), .OP(OP), .out_valid(ov1), .out_ready(out_ready),
        .O(o1), .Ovf(ovf1), .Zero(z1), .Ill(il1)
    );

    assign s_ir  = sel ? ir1  : ir0;
    assign s_ov  = sel ? ov1  : ov0;
    assign s_o   = sel ? o1   : o0;
    assign s_ovf = sel ? ovf1 : ovf0;
    assign s_z   = sel ? z1   : z0;
    assign s_il  = sel ? il1  : il0;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [3:0] op, input bit mul_en);
        exp_t e;
        logic [W:0] s;
        logic [2*W-1:0] p;
        e.o = '0; e.ovf = 1'b0; e.ill = 1'b0; e.lat = 1;
        case (op)
            4'd0:  e.o = a & b;
            4'd1:  e.o = a | b;
            4'd2: begin
                s = {a[W-1], a} + {b[W-1], b};
                e.o = s[W-1:0]; e.ovf = s[W] ^ s[W-1];
            end
            4'd6: begin
                s = {a[W-1], a} - {b[W-1], b};
                e.o = s[W-1:0]; e.ovf = s[W] ^ s[W-1];
            end
            4'd7:  e.o = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd12: e.o = ~(a | b);
            4'd8: begin
                if (mul_en) begin
                    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                    e.o = p[W-1:0]; e.ovf = |p[2*W-1:W]; e.lat = W + 1;
                end else begin
                    e.ill = 1'b1;
                end
            end
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.o == '0);
        return e;
    endfunction

    task automatic send(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] op, input bit which, input int hold);
        exp_t e;
        int t;
        int lat;
        sel = which;
        t = 0;
        while (s_ir !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (s_ir !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_wait: in_ready=%b required 1", tag, s_ir);
            return;
        end
        A = a; B = b; OP = op;
        if (which) iv1 = 1'b1;
        else iv0 = 1'b1;
        sb.push_back(model(a, b, op, !which));
        @(posedge clk);
        @(negedge clk);
        iv0 = 1'b0; iv1 = 1'b0;
        A = ~a; B = ~b; OP = 4'd1;
        checks++;
        if (s_ir !== 1'b0) begin
            failures++;
            $display("FAIL %s spacing: in_ready=%b required 0", tag, s_ir);
        end
        lat = 1;
        while (s_ov !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin
            failures++;
            $display("FAIL %s latency: got %0d required %0d", tag, lat, e.lat);
        end
        checks++;
        if (s_o !== e.o) begin
            failures++;
            $display("FAIL %s O: got %h required %h", tag, s_o, e.o);
        end
        checks++;
        if ({s_ovf, s_z, s_il} !== {e.ovf, e.zero, e.ill}) begin
            failures++;
            $display("FAIL %s flags ovf/zero/ill: got %b%b%b required %b%b%b",
                     tag, s_ovf, s_z, s_il, e.ovf, e.zero, e.ill);
        end
        for (int i = 0; i < hold; i++) begin
            A = $urandom; B = $urandom; OP = 4'd2;
            if (which) iv1 = 1'b1;
            else iv0 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            iv0 = 1'b0; iv1 = 1'b0;
            checks++;
            if ({s_ov, s_ir, s_o, s_ovf, s_z, s_il} !== {2'b10, e.o, e.ovf, e.zero, e.ill}) begin
                failures++;
                $display("FAIL %s hold%0d: ov=%b ir=%b O=%h flags=%b%b%b required ov=1 ir=0 O=%h flags=%b%b%b",
                         tag, i, s_ov, s_ir, s_o, s_ovf, s_z, s_il, e.o, e.ovf, e.zero, e.ill);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if ({s_ov, s_ir} !== 2'b01) begin
            failures++;
            $display("FAIL %s release: out_valid=%b in_ready=%b required 0 1", tag, s_ov, s_ir);
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        checks++;
        if ({ir0, ov0, o0, ovf0, z0, il0} !== {2'b10, {W{1'b0}}, 3'b000}) begin
            failures++;
            $display("FAIL reset_state: ir=%b ov=%b O=%h flags=%b%b%b required ir=1 ov=0 O=0 flags=000",
                     ir0, ov0, o0, ovf0, z0, il0);
        end
    endtask

    task automatic test_arith();
        send("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 1'b0, 0);
        send("add_neg", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 1'b0, 0);
        send("sub_eq", 64'd5, 64'd5, 4'b0110, 1'b0, 0);
        send("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 4'b0110, 1'b0, 0);
        send("slt_min", 64'h8000_0000_0000_0000, 64'd1, 4'b0111, 1'b0, 0);
        send("slt_neg", 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0111, 1'b0, 0);
        send("slt_wrap", 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 4'b0111, 1'b0, 0);
    endtask

    task automatic test_logic();
        send("and", 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FFFF, 4'b0000, 1'b0, 0);
        send("or", 64'hF000_0000_0000_000F, 64'h0000_1111_0000_0000, 4'b0001, 1'b0, 0);
        send("nor", 64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF, 4'b1100, 1'b0, 0);
    endtask

    task automatic test_mul();
        send("mul_32x32", 64'hFFFF_FFFF, 64'hFFFF_FFFF, 4'b1000, 1'b0, 0);
        send("mul_ovf", 64'h8000_0000_0000_0000, 64'd2, 4'b1000, 1'b0, 0);
        send("mul_full", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0, 0);
        send("mul_small", 64'd12345, 64'd678, 4'b1000, 1'b0, 0);
    endtask

    task automatic test_hold();
        send("hold_add", 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 4'b0010, 1'b0, 5);
        send("hold_mul", 64'hDEAD_BEEF, 64'h1234_5678_9ABC, 4'b1000, 1'b0, 5);
    endtask

    task automatic test_reset_mid_mul();
        int seen;
        sel = 1'b0;
        @(negedge clk);
        A = 64'h1234_5678; B = 64'h9ABC_DEF0; OP = 4'b1000; iv0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv0 = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({ov0, ir0} !== 2'b01) begin
            failures++;
            $display("FAIL rst_mul: out_valid=%b in_ready=%b required 0 1", ov0, ir0);
        end
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (ov0 === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rst_abort: out_valid cycles=%0d required 0", seen);
        end
        send("and_after_rst", 64'hF0, 64'h3C, 4'b0000, 1'b0, 0);
    endtask

    task automatic test_illegal();
        send("ill_0101", 64'hABCD, 64'h1234, 4'b0101, 1'b0, 0);
        send("ill_1111", 64'hFFFF, 64'h1, 4'b1111, 1'b0, 0);
        send("ill_mul_dis", 64'h3, 64'h5, 4'b1000, 1'b1, 0);
        send("legal_on_dis", 64'h3, 64'h5, 4'b0010, 1'b1, 0);
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [8];
        logic [3:0] op;
        logic [W-1:0] a, b;
        ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd8, 4'd5};
        for (int i = 0; i < 24; i++) begin
            op = ops[$urandom_range(0, 7)];
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 5 == 0) b = a;
            send("b2b", a, b, op, 1'b0, 0);
        end
    endtask

    initial begin
        rst = 1'b1; iv0 = 1'b0; iv1 = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; OP = '0; sel = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_arith();
        test_logic();
        test_mul();
        test_hold();
        test_reset_mid_mul();
        test_illegal();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
